// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access stage: execute bundle in, AXI4-Lite load/store, writeback bundle out
// Optional feature macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses without touching the bus.
module mem_access_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              mvalidX,
  input  logic              mwenX,
  input  logic [7:0]        mwmaskX,
  input  logic [2:0]        mrtypeX,
  input  logic [ADDR_W-1:0] addrX,
  input  logic [ADDR_W-1:0] wdataX,
  input  logic [4:0]        rdX,
  input  logic [2:0]        rdregsrcX,
  input  logic [ADDR_W-1:0] pcX,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ADDR_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] resultM,
  output logic [4:0]        rdM,
  output logic [2:0]        rdregsrcM,
  output logic [ADDR_W-1:0] pcM,
  output logic              bus_errM
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, WAIT_READY} state_t;

  state_t            state, state_nx;
  logic              aw_done, w_done;
  logic [ADDR_W-1:0] addr_q, wdata_q;
  logic [3:0]        mask_q;
  logic [2:0]        mrtype_q;
  logic [ADDR_W-1:0] shifted, load_val;
  logic              trap;
  logic              unused_mask_hi;

  assign unused_mask_hi = ^mwmaskX[7:4];

`ifdef LSU_MISALIGN_TRAP_EN
  logic is_half, is_word;
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    // Stores are sized by their byte mask, loads by their type.
    if (mwenX) begin
      is_word = mwmaskX[3];
      is_half = mwmaskX[1] && !mwmaskX[3];
    end else begin
      is_word = (mrtypeX == 3'd2);
      is_half = (mrtypeX == 3'd1) || (mrtypeX == 3'd5);
    end
  end
  assign trap = mvalidX && ((is_word && (addrX[1:0] != 2'b00)) || (is_half && addrX[0]));
`else
  assign trap = 1'b0;
`endif

  assign s_ready = (state == IDLE);
  assign m_valid = (state == WAIT_READY);
  assign araddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign wstrb   = mask_q << addr_q[1:0];
  assign wdata   = wdata_q << {addr_q[1:0], 3'b000};
  assign shifted = rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = shifted;
    case (mrtype_q)
      3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_val = {24'd0, shifted[7:0]};
      3'd5:    load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_nx = state;
    arvalid  = 1'b0;
    rready   = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          if (!mvalidX || trap) state_nx = WAIT_READY;
          else if (mwenX)       state_nx = WR_REQ;
          else                  state_nx = RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nx = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_nx = WAIT_READY;
      end
      WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nx = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nx = WAIT_READY;
      end
      WAIT_READY: begin
        if (m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= 4'd0;
      mrtype_q  <= 3'd0;
      resultM   <= '0;
      rdM       <= 5'd0;
      rdregsrcM <= 3'd0;
      pcM       <= RESET_PC;
      bus_errM  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (s_valid) begin
            addr_q    <= addrX;
            wdata_q   <= wdataX;
            mask_q    <= mwmaskX[3:0];
            mrtype_q  <= mrtypeX;
            rdM       <= rdX;
            rdregsrcM <= rdregsrcX;
            pcM       <= pcX;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            bus_errM  <= trap;
            if (!mvalidX || trap) resultM <= addrX;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            resultM  <= load_val;
            bus_errM <= (rresp != 2'b00);
          end
        end
        WR_REQ: begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready)   w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (bvalid) begin
            resultM  <= addr_q;
            bus_errM <= (bresp != 2'b00);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
// Honours LSU_MISALIGN_TRAP_EN in its reference model when the macro is defined.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready;
  logic        mvalidX, mwenX;
  logic [7:0]  mwmaskX;
  logic [2:0]  mrtypeX;
  logic [31:0] addrX, wdataX, pcX;
  logic [4:0]  rdX;
  logic [2:0]  rdregsrcX;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  logic        m_valid, m_ready, bus_errM;
  logic [31:0] resultM, pcM;
  logic [4:0]  rdM;
  logic [2:0]  rdregsrcM;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .mvalidX(mvalidX), .mwenX(mwenX), .mwmaskX(mwmaskX), .mrtypeX(mrtypeX),
    .addrX(addrX), .wdataX(wdataX), .rdX(rdX), .rdregsrcX(rdregsrcX), .pcX(pcX),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .m_valid(m_valid), .m_ready(m_ready), .resultM(resultM), .rdM(rdM),
    .rdregsrcM(rdregsrcM), .pcM(pcM), .bus_errM(bus_errM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mvalid, mwen;
    logic [7:0]  mask;
    logic [2:0]  mrtype;
    logic [31:0] addr, wdat, pc;
    logic [4:0]  rd;
    logic [2:0]  src;
    logic [31:0] rdat;
    logic [1:0]  resp;
    int          ar_w, r_w, aw_w, w_w, b_w, mr_w, lat;
    logic [31:0] exp_result;
    logic        exp_err;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic trap_model(input vec_t v);
`ifdef LSU_MISALIGN_TRAP_EN
    int size;
    if (!v.mvalid) return 1'b0;
    if (v.mwen) size = v.mask[3] ? 4 : (v.mask[1] ? 2 : 1);
    else size = (v.mrtype == 3'd2) ? 4 : ((v.mrtype == 3'd1 || v.mrtype == 3'd5) ? 2 : 1);
    return (v.addr % size) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Byte-view reference: bytes beyond the word end read as zero.
  function automatic logic [31:0] load_model(input logic [31:0] rd_word, input int a, input logic [2:0] t);
    logic [7:0] s [4];
    for (int i = 0; i < 4; i++) s[i] = (i + a < 4) ? rd_word[8*(i+a) +: 8] : 8'h00;
    case (t)
      3'd0:    return {{24{s[0][7]}}, s[0]};
      3'd1:    return {{16{s[1][7]}}, s[1], s[0]};
      3'd4:    return {24'd0, s[0]};
      3'd5:    return {16'd0, s[1], s[0]};
      default: return {s[3], s[2], s[1], s[0]};
    endcase
  endfunction

  function automatic vec_t fill_model(input vec_t v);
    int a = int'(v.addr[1:0]);
    v.exp_strb  = 4'd0;
    v.exp_wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (i >= a) begin
        v.exp_strb[i]          = v.mask[i-a];
        v.exp_wdata[8*i +: 8]  = v.wdat[8*(i-a) +: 8];
      end
    end
    if (!v.mvalid) begin
      v.exp_result = v.addr;  v.exp_err = 1'b0;
    end else if (trap_model(v)) begin
      v.exp_result = v.addr;  v.exp_err = 1'b1;
    end else if (v.mwen) begin
      v.exp_result = v.addr;  v.exp_err = (v.resp != 0);
    end else begin
      v.exp_result = load_model(v.rdat, a, v.mrtype);  v.exp_err = (v.resp != 0);
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic mv, input logic we, input logic [7:0] mask, input logic [2:0] t,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                              input logic [31:0] rdat, input logic [1:0] resp,
                              input int ar_w, input int r_w, input int aw_w, input int w_w, input int b_w,
                              input int mr_w, input int lat, input logic [31:0] er, input logic ee,
                              input logic [3:0] es, input logic [31:0] ew);
    vec_t v;
    v.mvalid = mv; v.mwen = we; v.mask = mask; v.mrtype = t; v.addr = addr; v.wdat = wd;
    v.rd = rd; v.src = rd[2:0] ^ 3'd5; v.pc = 32'h8000_1000 + {25'd0, rd, 2'b00};
    v.rdat = rdat; v.resp = resp;
    v.ar_w = ar_w; v.r_w = r_w; v.aw_w = aw_w; v.w_w = w_w; v.b_w = b_w; v.mr_w = mr_w; v.lat = lat;
    v.exp_result = er; v.exp_err = ee; v.exp_strb = es; v.exp_wdata = ew;
    return v;
  endfunction

  task automatic slave_idle();
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic run(input vec_t v);
    int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, any_valid = 0, cyc;
    logic mem;
    logic [31:0] waddr;
    mem   = v.mvalid && !trap_model(v);
    waddr = {v.addr[31:2], 2'b00};
    check("s_ready_idle", {31'd0, s_ready}, 32'd1);
    mvalidX = v.mvalid; mwenX = v.mwen; mwmaskX = v.mask; mrtypeX = v.mrtype; addrX = v.addr;
    wdataX = v.wdat; rdX = v.rd; rdregsrcX = v.src; pcX = v.pc; s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    cyc = 1;
    while (!m_valid && cyc < 200) begin
      slave_idle();
      if (arvalid) begin
        any_valid++;
        check("araddr", araddr, waddr);
        if (v.ar_w == 0) begin arready = 1; ar_hs++; end else v.ar_w--;
      end
      if (rready) begin
        if (v.r_w == 0) begin rvalid = 1; rdata = v.rdat; rresp = v.resp; r_hs++; end else v.r_w--;
      end
      if (awvalid) begin
        any_valid++;
        check("awaddr", awaddr, waddr);
        if (v.aw_w == 0) begin awready = 1; aw_hs++; end else v.aw_w--;
      end
      if (wvalid) begin
        any_valid++;
        check("wstrb", {28'd0, wstrb}, {28'd0, v.exp_strb});
        check("wdata", wdata, v.exp_wdata);
        if (v.w_w == 0) begin wready = 1; w_hs++; end else v.w_w--;
      end
      if (bready) begin
        if (v.b_w == 0) begin bvalid = 1; bresp = v.resp; b_hs++; end else v.b_w--;
      end
      @(negedge clk);
      cyc++;
    end
    slave_idle();
    rresp = 0; bresp = 0;
    check("m_valid_timeout", {31'd0, m_valid}, 32'd1);
    if (v.lat > 0) check("latency", cyc, v.lat);
    check("resultM", resultM, v.exp_result);
    check("bus_errM", {31'd0, bus_errM}, {31'd0, v.exp_err});
    check("rdM", {27'd0, rdM}, {27'd0, v.rd});
    check("rdregsrcM", {29'd0, rdregsrcM}, {29'd0, v.src});
    check("pcM", pcM, v.pc);
    if (!mem) check("no_axi_valid", any_valid, 0);
    else if (v.mwen) begin
      check("aw_handshakes", aw_hs, 1);
      check("w_handshakes", w_hs, 1);
      check("b_handshakes", b_hs, 1);
    end else begin
      check("ar_handshakes", ar_hs, 1);
      check("r_handshakes", r_hs, 1);
    end
    for (int i = 0; i < v.mr_w; i++) begin
      @(negedge clk);
      check("hold_m_valid", {31'd0, m_valid}, 32'd1);
      check("hold_s_ready", {31'd0, s_ready}, 32'd0);
      check("hold_resultM", resultM, v.exp_result);
      check("hold_bus_errM", {31'd0, bus_errM}, {31'd0, v.exp_err});
    end
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
    check("released_m_valid", {31'd0, m_valid}, 32'd0);
    check("released_s_ready", {31'd0, s_ready}, 32'd1);
  endtask

  initial begin
    vec_t tbl [9];
    vec_t v;
    logic [7:0] masks [3];
    logic [2:0] types [6];
    masks[0] = 8'h01; masks[1] = 8'h03; masks[2] = 8'h0F;
    types[0] = 3'd0; types[1] = 3'd1; types[2] = 3'd2; types[3] = 3'd4; types[4] = 3'd5; types[5] = 3'd3;

    tbl[0] = mk(1'b0, 1'b0, 8'h01, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0, 1,
                32'h0000_1234, 1'b0, 4'h0, 32'h0);
    tbl[1] = mk(1'b1, 1'b0, 8'h01, 3'd0, 32'h8000_0003, 32'h0, 5'd6, 32'h80FF_0000, 2'd0, 0, 0, 0, 0, 0, 0, 3,
                32'hFFFF_FF80, 1'b0, 4'h0, 32'h0);
    tbl[2] = mk(1'b1, 1'b0, 8'h03, 3'd5, 32'h8000_0002, 32'h0, 5'd7, 32'hBEEF_1234, 2'd0, 1, 2, 0, 0, 0, 1, 0,
                32'h0000_BEEF, 1'b0, 4'h0, 32'h0);
    tbl[3] = mk(1'b1, 1'b1, 8'h01, 3'd0, 32'h8000_0001, 32'h0000_00AB, 5'd8, 32'h0, 2'd0, 0, 0, 0, 1, 0, 0, 0,
                32'h8000_0001, 1'b0, 4'b0010, 32'h0000_AB00);
    tbl[4] = mk(1'b1, 1'b1, 8'h01, 3'd0, 32'h8000_0001, 32'h0000_00AB, 5'd9, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0, 0,
                32'h8000_0001, 1'b0, 4'b0010, 32'h0000_AB00);
    tbl[5] = mk(1'b1, 1'b1, 8'h0F, 3'd0, 32'h8000_0010, 32'hDEAD_BEEF, 5'd10, 32'h0, 2'b10, 0, 0, 0, 0, 1, 3, 0,
                32'h8000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
    tbl[6] = mk(1'b1, 1'b0, 8'h03, 3'd1, 32'h8000_0000, 32'h0, 5'd11, 32'h0000_8001, 2'b11, 0, 0, 0, 0, 0, 0, 0,
                32'hFFFF_8001, 1'b1, 4'h0, 32'h0);
    tbl[7] = mk(1'b1, 1'b0, 8'h0F, 3'd2, 32'h8000_0004, 32'h0, 5'd12, 32'h1234_5678, 2'd0, 0, 0, 0, 0, 0, 0, 0,
                32'h1234_5678, 1'b0, 4'h0, 32'h0);
    tbl[8] = mk(1'b1, 1'b1, 8'h03, 3'd0, 32'h8000_0022, 32'h1234_CDEF, 5'd13, 32'h0, 2'd0, 0, 0, 2, 0, 0, 0, 0,
                32'h8000_0022, 1'b0, 4'b1100, 32'hCDEF_0000);

    rst = 0; s_valid = 0; m_ready = 0; mvalidX = 0; mwenX = 0; mwmaskX = 0; mrtypeX = 0;
    addrX = 0; wdataX = 0; rdX = 0; rdregsrcX = 0; pcX = 0; rdata = 0; rresp = 0; bresp = 0;
    slave_idle();
    repeat (2) @(negedge clk);
    check("reset_s_ready", {31'd0, s_ready}, 32'd1);
    check("reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("reset_axi_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    check("reset_pcM", pcM, 32'h8000_0000);
    check("reset_resultM", resultM, 32'd0);
    check("reset_rdM", {27'd0, rdM}, 32'd0);
    check("reset_bus_errM", {31'd0, bus_errM}, 32'd0);
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, masks[$urandom_range(0, 2)],
             types[$urandom_range(0, 5)], $urandom, $urandom, 5'($urandom), $urandom,
             ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0,
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 2), $urandom_range(0, 2), 0, 32'h0, 1'b0, 4'h0, 32'h0);
      run(fill_model(v));
    end

    // Reset while waiting for read data: the late beat must be dropped.
    mvalidX = 1; mwenX = 0; mrtypeX = 3'd2; mwmaskX = 8'h0F; addrX = 32'h8000_0040;
    rdX = 5'd9; rdregsrcX = 3'd2; pcX = 32'h8000_2000; s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    check("rstseq_arvalid", {31'd0, arvalid}, 32'd1);
    arready = 1;
    @(negedge clk);
    arready = 0;
    check("rstseq_rready", {31'd0, rready}, 32'd1);
    check("rstseq_pc_latched", pcM, 32'h8000_2000);
    rst = 0;
    @(negedge clk);
    rst = 1;
    check("rstseq_axi_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    check("rstseq_pcM", pcM, 32'h8000_0000);
    check("rstseq_rdM", {27'd0, rdM}, 32'd0);
    check("rstseq_s_ready", {31'd0, s_ready}, 32'd1);
    check("rstseq_m_valid", {31'd0, m_valid}, 32'd0);
    rvalid = 1; rdata = 32'hCAFE_F00D;
    @(negedge clk);
    rvalid = 0;
    check("late_rvalid_m_valid", {31'd0, m_valid}, 32'd0);
    check("late_rvalid_resultM", resultM, 32'd0);
    @(negedge clk);
    check("late_rvalid_idle", {30'd0, s_ready, m_valid}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Downstream consumer of the execute-stage register bundle; accepts one instruction per s_valid/s_ready handshake.
- Performs the load/store over an AXI4-Lite master port, then presents a registered writeback bundle on m_valid/m_ready.
- Sits between the execute register stage and the writeback stage in the multi-cycle/pipelined NPC core.

Parameters:
- RESET_PC, 32'h80000000, reset value of pcM.
- ADDR_W, 32, address and data width; only 32 is supported.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- s_valid  input  1  execute bundle valid.
- s_ready  output  1  stage can accept a bundle.
- mvalidX  input  1  instruction accesses memory.
- mwenX  input  1  1 = store, 0 = load.
- mwmaskX  input  8  byte mask, low-aligned; bits [3:0] used.
- mrtypeX  input  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- addrX  input  32  ALU result: memory address or non-memory result.
- wdataX  input  32  store data, low-aligned.
- rdX  input  5  destination register.
- rdregsrcX  input  3  writeback source select (passthrough).
- pcX  input  32  instruction PC (passthrough).
- araddr, arvalid, arready  out/out/in  32/1/1  AXI read address channel.
- rdata, rresp, rvalid, rready  in/in/in/out  32/2/1/1  AXI read data channel.
- awaddr, awvalid, awready  out/out/in  32/1/1  AXI write address channel.
- wdata, wstrb, wvalid, wready  out/out/out/in  32/4/1/1  AXI write data channel.
- bresp, bvalid, bready  in/in/out  2/1/1  AXI write response channel.
- m_valid  output  1  writeback bundle valid.
- m_ready  input  1  writeback stage accepts the bundle.
- resultM  output  32  load data (extended) or addrX passthrough.
- rdM  output  5  registered rdX.
- rdregsrcM  output  3  registered rdregsrcX.
- pcM  output  32  registered pcX.
- bus_errM  output  1  nonzero rresp/bresp seen (or misaligned access, with the optional feature).

Behaviour:
- Reset (rst == 0 at posedge):
  - state = IDLE.
  - All AXI valids, rready and bready = 0.
  - resultM = 0, rdM = 0, rdregsrcM = 0, pcM = RESET_PC, bus_errM = 0.
  - Any in-flight transaction is abandoned; no completion is reported afterwards.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, WAIT_READY.
- s_ready = (state == IDLE). m_valid = (state == WAIT_READY).
- IDLE, on s_valid: latch all X inputs into internal registers, then branch:
  - mvalidX == 0: resultM <= addrX; go to WAIT_READY. Latency 1 cycle.
  - Load: go to RD_ADDR; arvalid = 1, araddr = {addr[31:2], 2'b00}.
  - Store: go to WR_REQ; awvalid = wvalid = 1.
    - awaddr = word-aligned address.
    - wstrb = mask[3:0] << addr[1:0].
    - wdata = wdataX << (8*addr[1:0]).
- RD_ADDR: hold arvalid and araddr until arready; then go to RD_DATA with rready = 1.
- RD_DATA: on rvalid, extract and extend, then go to WAIT_READY.
  - Shift: rdata >> (8*addr[1:0]).
  - Extend by mrtype: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW as-is.
  - Any other mrtype returns the raw shifted word.
  - bus_errM <= (rresp != 0).
- WR_REQ: AW and W channels handshake independently.
  - Each valid drops after its own handshake; track aw_done and w_done.
  - Simultaneous arrival of both handshakes in one cycle is legal.
  - When both are done, go to WR_RESP with bready = 1.
- WR_RESP: on bvalid, resultM <= addrX, bus_errM <= (bresp != 0), go to WAIT_READY.
- WAIT_READY: hold all M outputs stable; on m_ready go to IDLE.
  - No new bundle is accepted in the same cycle (s_ready low in WAIT_READY).
  - Throughput is at most 1 bundle per 2 cycles.
- AXI outputs and the latched bundle are stable while their valid is high and unacknowledged.
- Zero-latency slave (arready/rvalid asserted in the cycle right after the request): total load latency is 3 cycles from handshake to m_valid.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses issue no bus transaction; go straight to WAIT_READY with bus_errM = 1 and resultM = addrX.
  - Halfword misaligned: addr[0] != 0.
  - Word misaligned: addr[1:0] != 0.
- Undefined: no check. Accesses crossing a word boundary use only the in-word bytes (the shifted wstrb is truncated to 4 bits).

Test Plan:
- ALU op: s_valid with mvalidX = 0, addrX = 0x1234, rdX = 5 -> m_valid next cycle, resultM = 0x1234, rdM = 5, no AXI valid asserted.
- LB sign-extend: addr = 0x80000003, rdata = 0x80FF_0000 -> araddr = 0x80000000, resultM = 0xFFFF_FF80, bus_errM = 0.
- LHU: addr = 0x80000002, rdata = 0xBEEF_1234 -> resultM = 0x0000_BEEF.
- SB: addr = 0x80000001, wdataX = 0xAB, mask = 0x01 -> wstrb = 4'b0010, wdata = 0x0000_AB00.
  - Run with awready a cycle before wready, then with both in the same cycle -> single bready handshake each time.
- Backpressure and error: bresp = 2'b10, m_ready held low 3 cycles -> bus_errM = 1, outputs stable, s_ready low until m_ready.
- Reset in RD_DATA: rst low for one cycle -> all valids 0, pcM = 0x80000000, s_ready = 1; a late rvalid is ignored.
